// File: rtl/idu_stage.sv
// Pipelined RV instruction decoder: combinational field/type/immediate decode feeding a
// registered output stage with a one-entry skid buffer behind valid/ready handshakes.
module idu_stage #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned PC_W    = 64,
   parameter bit          HAS_FP  = 1'b0,
   parameter bit          HAS_AMO = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_type,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      TYPE_R    = 3'd0,
      TYPE_I    = 3'd1,
      TYPE_S    = 3'd2,
      TYPE_B    = 3'd3,
      TYPE_U    = 3'd4,
      TYPE_J    = 3'd5,
      TYPE_R4   = 3'd6,
      TYPE_NONE = 3'd7
   } inst_type_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     inst;
      inst_type_e      ty;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } bundle_t;

   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_LOAD_FP   = 7'h07;
   localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
   localparam logic [6:0] OPC_STORE     = 7'h23;
   localparam logic [6:0] OPC_STORE_FP  = 7'h27;
   localparam logic [6:0] OPC_AMO       = 7'h2F;
   localparam logic [6:0] OPC_OP        = 7'h33;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_OP_32     = 7'h3B;
   localparam logic [6:0] OPC_MADD      = 7'h43;
   localparam logic [6:0] OPC_MSUB      = 7'h47;
   localparam logic [6:0] OPC_NMSUB     = 7'h4B;
   localparam logic [6:0] OPC_NMADD     = 7'h4F;
   localparam logic [6:0] OPC_OP_FP     = 7'h53;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_JAL       = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM    = 7'h73;

   bundle_t    dec;
   bundle_t    main_q;
   bundle_t    skid_q;
   logic       skid_valid;
   inst_type_e dec_type;
   logic       is_fp;
   logic       is_amo;
   logic       is_w;

   // Type is looked up on the full 7-bit opcode, so compressed encodings land on NONE.
   always_comb begin
      dec_type = TYPE_NONE;
      is_fp    = 1'b0;
      is_amo   = 1'b0;
      is_w     = 1'b0;
      case (in_inst[6:0])
         OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: dec_type = TYPE_I;
         OPC_LOAD_FP:   begin dec_type = TYPE_I;  is_fp = 1'b1; end
         OPC_OP_IMM_32: begin dec_type = TYPE_I;  is_w  = 1'b1; end
         OPC_STORE:     dec_type = TYPE_S;
         OPC_STORE_FP:  begin dec_type = TYPE_S;  is_fp = 1'b1; end
         OPC_BRANCH:    dec_type = TYPE_B;
         OPC_AUIPC, OPC_LUI: dec_type = TYPE_U;
         OPC_JAL:       dec_type = TYPE_J;
         OPC_OP:        dec_type = TYPE_R;
         OPC_OP_32:     begin dec_type = TYPE_R;  is_w   = 1'b1; end
         OPC_AMO:       begin dec_type = TYPE_R;  is_amo = 1'b1; end
         OPC_OP_FP:     begin dec_type = TYPE_R;  is_fp  = 1'b1; end
         OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin dec_type = TYPE_R4; is_fp = 1'b1; end
         default:       dec_type = TYPE_NONE;
      endcase
   end

   always_comb begin
      dec      = '0;
      dec.pc   = in_pc;
      dec.inst = in_inst;
      dec.ty   = dec_type;
      case (dec_type)
         TYPE_I:  dec.imm = XLEN'($signed(in_inst[31:20]));
         TYPE_S:  dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
         TYPE_B:  dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                            in_inst[11:8], 1'b0}));
         TYPE_U:  dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
         TYPE_J:  dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                            in_inst[30:21], 1'b0}));
         default: dec.imm = '0;
      endcase
      dec.illegal = (in_inst[1:0] != 2'b11) || (dec_type == TYPE_NONE) ||
                    (is_fp && !HAS_FP) || (is_amo && !HAS_AMO) || (is_w && (XLEN == 32));
   end

   assign in_ready = !skid_valid;

   // While the skid is occupied in_ready is low, so the input can be ignored in that branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (out_ready) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end
      end else if (!out_valid || out_ready) begin
         out_valid <= in_valid;
         if (in_valid) main_q <= dec;
      end else if (in_valid) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_pc      = main_q.pc;
   assign out_opcode  = main_q.inst[6:0];
   assign out_funct3  = main_q.inst[14:12];
   assign out_funct7  = main_q.inst[31:25];
   assign out_rs1     = main_q.inst[19:15];
   assign out_rs2     = main_q.inst[24:20];
   assign out_rd      = main_q.inst[11:7];
   assign out_type    = main_q.ty;
   assign out_imm     = main_q.imm;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: arithmetic decode model plus a FIFO occupancy model, checked every
// cycle, with directed literal cases and a randomized stream including flushes.
module tb_idu_stage;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned PC_W    = 64;
   localparam bit          HAS_FP  = 1'b0;
   localparam bit          HAS_AMO = 1'b1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [31:0]     in_inst = '0;
   logic [PC_W-1:0] in_pc = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [PC_W-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic [2:0]      out_type;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   idu_stage #(.XLEN(XLEN), .PC_W(PC_W), .HAS_FP(HAS_FP), .HAS_AMO(HAS_AMO)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_type(out_type),
      .out_imm(out_imm), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Decode rules expressed as weighted bit sums; a set sign bit subtracts its field range.
   function automatic void ref_decode(input logic [31:0] i, output int ty, output longint imm,
                                      output bit ill);
      logic [6:0] o;
      o   = i[6:0];
      imm = 0;
      case (o)
         7'h03, 7'h07, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: ty = 1;
         7'h23, 7'h27: ty = 2;
         7'h63:        ty = 3;
         7'h17, 7'h37: ty = 4;
         7'h6F:        ty = 5;
         7'h33, 7'h3B, 7'h53, 7'h2F: ty = 0;
         7'h43, 7'h47, 7'h4B, 7'h4F: ty = 6;
         default:      ty = 7;
      endcase
      case (ty)
         1: imm = longint'(i[31:20]) - (i[31] ? 4096 : 0);
         2: imm = longint'({i[31:25], i[11:7]}) - (i[31] ? 4096 : 0);
         3: imm = longint'(i[11:8]) * 2 + longint'(i[30:25]) * 32 + longint'(i[7]) * 2048
                  - (i[31] ? 4096 : 0);
         4: imm = longint'(i[31:12]) * 4096 - (i[31] ? 64'sh1_0000_0000 : 0);
         5: imm = longint'(i[30:21]) * 2 + longint'(i[20]) * 2048 + longint'(i[19:12]) * 4096
                  - (i[31] ? 1048576 : 0);
         default: imm = 0;
      endcase
      ill = (i[1:0] != 2'b11) || (ty == 7) ||
            (!HAS_FP && (o inside {7'h07, 7'h27, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F})) ||
            (!HAS_AMO && o == 7'h2F) || (XLEN == 32 && (o inside {7'h1B, 7'h3B}));
   endfunction

   typedef struct {
      logic [PC_W-1:0] pc;
      logic [31:0]     inst;
   } entry_t;

   entry_t q[$];
   bit     acc = 1'b0;

   // Two-deep FIFO model: accept while fewer than two bundles held; flush drops everything.
   always @(posedge clk or negedge rst_n) begin
      bit do_in;
      if (!rst_n) begin
         q.delete();
         acc = 1'b0;
      end else begin
         acc = 1'b0;
         if (flush) q.delete();
         else begin
            do_in = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (do_in) begin
               q.push_back('{pc: in_pc, inst: in_inst});
               acc = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      int     ty;
      longint imm;
      bit     ill;
      if (rst_n) begin
         check("in_ready", 64'(in_ready), 64'(q.size() < 2));
         check("out_valid", 64'(out_valid), 64'(q.size() > 0));
         if (q.size() > 0 && out_valid) begin
            ref_decode(q[0].inst, ty, imm, ill);
            check("out_pc", 64'(out_pc), 64'(q[0].pc));
            check("opcode", 64'(out_opcode), 64'(q[0].inst[6:0]));
            check("funct3", 64'(out_funct3), 64'(q[0].inst[14:12]));
            check("funct7", 64'(out_funct7), 64'(q[0].inst[31:25]));
            check("rs1", 64'(out_rs1), 64'(q[0].inst[19:15]));
            check("rs2", 64'(out_rs2), 64'(q[0].inst[24:20]));
            check("rd", 64'(out_rd), 64'(q[0].inst[11:7]));
            check("type", 64'(out_type), 64'(ty));
            check("imm", 64'(out_imm), 64'(imm));
            check("illegal", 64'(out_illegal), 64'(ill));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic one(input logic [31:0] inst);
      in_inst  = inst;
      in_pc    = 64'h1000 + 64'(inst[15:0]);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_hold(input logic [31:0] inst, input logic [PC_W-1:0] pc);
      bit done;
      done     = 1'b0;
      in_inst  = inst;
      in_pc    = pc;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         cyc();
         done = acc;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   logic [6:0] opc_list [21] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h27,
                                 7'h2F, 7'h33, 7'h37, 7'h3B, 7'h43, 7'h47, 7'h4B, 7'h4F,
                                 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r;
      #12 rst_n = 1'b1;
      @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);

      out_ready = 1'b1;
      one(32'hFFF00093);
      check("addi_valid", 64'(out_valid), 64'd1);
      check("addi_type", 64'(out_type), 64'd1);
      check("addi_rd", 64'(out_rd), 64'd1);
      check("addi_rs1", 64'(out_rs1), 64'd0);
      check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_illegal", 64'(out_illegal), 64'd0);
      one(32'h800002B7);
      check("lui_imm", 64'(out_imm), 64'hFFFF_FFFF_8000_0000);
      one(32'hFFDFF06F);
      check("jal_type", 64'(out_type), 64'd5);
      check("jal_imm", 64'(out_imm), 64'hFFFF_FFFF_FFFF_FFFC);
      one(32'hFE000EE3);
      check("beq_type", 64'(out_type), 64'd3);
      check("beq_imm", 64'(out_imm), 64'hFFFF_FFFF_FFFF_FFFC);
      one(32'h00000000);
      check("zero_illegal", 64'(out_illegal), 64'd1);
      one(32'h0000000B);
      check("custom0_illegal", 64'(out_illegal), 64'd1);
      check("custom0_type", 64'(out_type), 64'd7);
      check("custom0_imm", 64'(out_imm), 64'd0);
      one(32'h00002007);
      check("flw_illegal", 64'(out_illegal), 64'd1);
      cyc();

      // Stall: two accepted, third blocked, outputs frozen for three cycles.
      out_ready = 1'b0;
      send_hold(32'h00A00113, 64'hA0);
      send_hold(32'h00B00193, 64'hA4);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      in_inst  = 32'h00C00213;
      in_pc    = 64'hA8;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("stall_hold_pc", 64'(out_pc), 64'hA0);
      end
      out_ready = 1'b1;
      send_hold(32'h00C00213, 64'hA8);
      send_hold(32'h00D00293, 64'hAC);
      repeat (4) cyc();

      // Flush with both entries full and a beat presented.
      out_ready = 1'b0;
      send_hold(32'h00100313, 64'hB0);
      send_hold(32'h00200393, 64'hB4);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_inst  = 32'h00300413;
      in_pc    = 64'hB8;
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      send_hold(32'h00400493, 64'hBC);
      check("post_flush_pc", 64'(out_pc), 64'hBC);
      cyc();

      // Asynchronous reset pulse between edges with two bundles buffered.
      out_ready = 1'b0;
      send_hold(32'h00500513, 64'hC0);
      send_hold(32'h00600593, 64'hC4);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         if ($urandom_range(3) != 0) r[6:0] = opc_list[$urandom_range(20)];
         in_inst   = r;
         in_pc     = {$urandom, $urandom};
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(49) == 0);
         cyc();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
